// File: rtl/mult_pkg.sv
// Shared types and sizing constants for the sequential add-shift multiplier.
package mult_pkg;

    // Operand width; the nine-bit adder fixes this at 8.
    localparam int MULT_WIDTH = 8;

    // One add/shift iteration per multiplier bit.
    localparam int MULT_ITERS = 8;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : mult_pkg

// File: rtl/nine_bit_adder.sv
// Nine-bit signed adder: sign-extends two 8-bit operands and adds a carry-in.
// The extra bit keeps the true sign of the sum, which feeds the X register.
module nine_bit_adder
    import mult_pkg::*;
(
    input  logic [MULT_WIDTH-1:0] a,
    input  logic [MULT_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [MULT_WIDTH:0]   sum
);

    logic signed [MULT_WIDTH:0] a_ext;
    logic signed [MULT_WIDTH:0] b_ext;
    logic        [MULT_WIDTH:0] cin_ext;

    // Sign-extend both operands so the ninth bit is the real sign of the sum.
    always_comb begin
        a_ext   = {a[MULT_WIDTH-1], a};
        b_ext   = {b[MULT_WIDTH-1], b};
        cin_ext = {{MULT_WIDTH{1'b0}}, cin};
        sum     = a_ext + b_ext + cin_ext;
    end

endmodule : nine_bit_adder

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 two's-complement multiplier using add-shift.
// The product ends up in A:B (A = high byte), X holds the sign extension.
// The multiplicand is taken from S on every iteration; the multiplier is
// loaded into B beforehand and is consumed one bit per iteration from B[0].
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH      = MULT_WIDTH,
    parameter int ITERATIONS = MULT_ITERS
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    // Only the 8-bit, 8-iteration configuration matches the fixed adder.
    if (WIDTH != MULT_WIDTH || ITERATIONS != WIDTH) begin : g_bad_param
        $error("shift_add_multiplier: WIDTH must be 8 and ITERATIONS must equal WIDTH");
    end

    // Counter value of the final (sign-bit) iteration.
    localparam logic [2:0] LAST_K = 3'(ITERATIONS - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             x_reg;
    logic [2:0]       k;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum9;

    // The multiplier's MSB carries negative weight, so the last iteration
    // subtracts S (A + ~S + 1) instead of adding it.
    always_comb begin
        add_b   = S;
        add_cin = 1'b0;
        if (k == LAST_K) begin
            add_b   = ~S;
            add_cin = 1'b1;
        end
    end

    nine_bit_adder u_adder (
        .a   (a_reg),
        .b   (add_b),
        .cin (add_cin),
        .sum (sum9)
    );

    // Control FSM plus the X:A:B datapath registers, with registered status flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            x_reg    <= 1'b0;
            k        <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Run wins over a simultaneous load so B keeps the multiplier.
                    if (Run) begin
                        a_reg    <= '0;
                        x_reg    <= 1'b0;
                        k        <= '0;
                        state    <= ADD;
                        busy_reg <= 1'b1;
                    end else if (ClearA_LoadB) begin
                        a_reg <= '0;
                        x_reg <= 1'b0;
                        b_reg <= S;
                    end
                end

                ADD: begin
                    if (b_reg[0]) begin
                        x_reg <= sum9[WIDTH];
                        a_reg <= sum9[WIDTH-1:0];
                    end
                    state <= SHIFT;
                end

                SHIFT: begin
                    // Arithmetic right shift of X:A:B; X replicates the sign.
                    a_reg <= {x_reg, a_reg[WIDTH-1:1]};
                    b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
                    if (k == LAST_K) begin
                        state    <= DONE;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end else begin
                        k     <= k + 3'd1;
                        state <= ADD;
                    end
                end

                DONE: begin
                    // Hold the product; a still-asserted Run must not restart.
                    if (!Run) begin
                        state    <= IDLE;
                        done_reg <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign Aval = a_reg;
    assign Bval = b_reg;
    assign X    = x_reg;
    assign Busy = busy_reg;
    assign Done = done_reg;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: arithmetic reference model plus directed vectors.
module tb_shift_add_multiplier;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] S;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       Busy;
    logic       Done;

    int n_vec  = 0;
    int n_miss = 0;

    shift_add_multiplier dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .S            (S),
        .Aval         (Aval),
        .Bval         (Bval),
        .X            (X),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks only phase and the arithmetic result.
    typedef enum {M_IDLE, M_BUSY, M_DONE} mph_t;
    mph_t              m_ph  = M_IDLE;
    int                m_cnt = 0;
    logic [7:0]        m_a   = 8'h00;
    logic [7:0]        m_b   = 8'h00;
    logic              m_x   = 1'b0;
    logic signed [15:0] m_prod = 16'sd0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_ph  = M_IDLE;
            m_cnt = 0;
            m_a   = 8'h00;
            m_b   = 8'h00;
            m_x   = 1'b0;
        end else begin
            case (m_ph)
                M_IDLE: begin
                    if (Run) begin
                        m_a    = 8'h00;
                        m_x    = 1'b0;
                        m_prod = $signed(S) * $signed(m_b);
                        m_cnt  = 16;
                        m_ph   = M_BUSY;
                    end else if (ClearA_LoadB) begin
                        m_a = 8'h00;
                        m_x = 1'b0;
                        m_b = S;
                    end
                end
                M_BUSY: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_a  = m_prod[15:8];
                        m_b  = m_prod[7:0];
                        m_x  = m_prod[15];
                        m_ph = M_DONE;
                    end
                end
                M_DONE: begin
                    if (!Run) m_ph = M_IDLE;
                end
                default: m_ph = M_IDLE;
            endcase
        end
    end

    // Compare DUT against the model every cycle; registers only when not mid-multiply.
    always @(negedge Clk) begin
        check("busy", 32'(Busy), 32'(m_ph == M_BUSY));
        check("done", 32'(Done), 32'(m_ph == M_DONE));
        if (m_ph != M_BUSY) begin
            check("model_a", 32'(Aval), 32'(m_a));
            check("model_b", 32'(Bval), 32'(m_b));
            check("model_x", 32'(X), 32'(m_x));
        end
    end

    task automatic load_b(input logic [7:0] v);
        @(negedge Clk);
        ClearA_LoadB = 1'b1;
        S            = v;
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
    endtask

    // Called at a negedge; returns the number of cycles until Done is seen.
    task automatic run_mult(input logic [7:0] s, input bit hold, output int lat);
        S   = s;
        Run = 1'b1;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
            if (lat == 1) begin
                ClearA_LoadB = 1'b0;
                if (!hold) Run = 1'b0;
            end
        end while (!Done && lat < 40);
    endtask

    typedef struct {
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ex;
    } vec_t;

    vec_t vecs[5] = '{
        '{8'h03, 8'h07, 8'h00, 8'h15, 1'b0},  //    7 x 3    = 21
        '{8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0},  //   -1 x -1   = 1
        '{8'h80, 8'h7F, 8'hC0, 8'h80, 1'b1},  //  127 x -128 = -16256
        '{8'h80, 8'h80, 8'h40, 8'h00, 1'b0},  // -128 x -128 = 16384
        '{8'h05, 8'hFD, 8'hFF, 8'hF1, 1'b1}   //   -3 x 5    = -15
    };

    initial begin
        int lat;
        Reset_n      = 1'b0;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        S            = 8'h00;
        repeat (2) @(negedge Clk);
        check("rst_a", 32'(Aval), 32'h00);
        check("rst_b", 32'(Bval), 32'h00);
        check("rst_x", 32'(X), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_done", 32'(Done), 32'h0);
        Reset_n = 1'b1;
        @(negedge Clk);

        foreach (vecs[i]) begin
            load_b(vecs[i].b);
            run_mult(vecs[i].s, 1'b0, lat);
            check("latency", 32'(lat), 32'd17);
            check("prod_a", 32'(Aval), 32'(vecs[i].ea));
            check("prod_b", 32'(Bval), 32'(vecs[i].eb));
            check("prod_x", 32'(X), 32'(vecs[i].ex));
            @(negedge Clk);
            check("back_idle", 32'(Done), 32'h0);
        end

        // Run held through DONE: no restart, registers stable.
        load_b(8'h03);
        run_mult(8'h07, 1'b1, lat);
        check("hold_latency", 32'(lat), 32'd17);
        repeat (3) begin
            @(negedge Clk);
            check("hold_done", 32'(Done), 32'h1);
            check("hold_busy", 32'(Busy), 32'h0);
            check("hold_b", 32'(Bval), 32'h15);
        end
        Run = 1'b0;
        @(negedge Clk);
        check("release_done", 32'(Done), 32'h0);

        // Run and ClearA_LoadB together: B keeps 0x03, computes 5 x 3.
        load_b(8'h03);
        ClearA_LoadB = 1'b1;
        run_mult(8'h05, 1'b0, lat);
        check("prio_latency", 32'(lat), 32'd17);
        check("prio_a", 32'(Aval), 32'h00);
        check("prio_b", 32'(Bval), 32'h0F);
        @(negedge Clk);

        // Asynchronous reset during iteration 4.
        load_b(8'h03);
        S   = 8'h07;
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        repeat (8) @(negedge Clk);
        check("mid_busy", 32'(Busy), 32'h1);
        #2 Reset_n = 1'b0;
        #1;
        check("abort_a", 32'(Aval), 32'h00);
        check("abort_b", 32'(Bval), 32'h00);
        check("abort_x", 32'(X), 32'h0);
        check("abort_busy", 32'(Busy), 32'h0);
        check("abort_done", 32'(Done), 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        load_b(8'h03);
        run_mult(8'h07, 1'b0, lat);
        check("rerun_latency", 32'(lat), 32'd17);
        check("rerun_a", 32'(Aval), 32'h00);
        check("rerun_b", 32'(Bval), 32'h15);
        check("rerun_x", 32'(X), 32'h0);
        @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_miss);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_shift_add_multiplier

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential 8x8 signed (two's-complement) multiplier: registers X, A, B plus control FSM, using add-shift.
- Directly upstream/consumer of nine_bit_adder: sources its A and B operands, consumes its 9-bit sum.
- Multiplicand comes from switch input S. Multiplier is loaded into B. The 16-bit product is left in A:B, with X holding the sign extension.

Parameters:
- WIDTH, 8, operand width. Only 8 is legal, because the adder is fixed at 8/9 bits.
- ITERATIONS, 8, number of add/shift iterations. Must equal WIDTH.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Run  input  1  level start request, sampled in IDLE.
- ClearA_LoadB  input  1  in IDLE: clear A and X, load B from S.
- S  input  8  multiplicand (switches).
- Aval  output  8  register A (product high byte).
- Bval  output  8  register B (product low byte).
- X  output  1  sign-extension register.
- Busy  output  1  high in ADD/SHIFT states.
- Done  output  1  high in DONE state.

Behaviour:
- Reset (async, Reset_n=0):
  - A=0x00, B=0x00, X=0, state=IDLE, internal counter=0.
  - Busy=0, Done=0.
  - Assertion mid-operation aborts immediately with no partial result preserved.
  - Release is synchronised by the FSM; the first active edge after release sees IDLE.
- Adder hookup:
  - Adder A input = A register.
  - Iterations 0..6: B input = S, cin=0.
  - Iteration 7: B input = ~S, cin=1 (subtract: MSB of multiplier has negative weight).
  - Sum is 9 bits: S9[8] goes to X, S9[7:0] goes to A.
- States: IDLE, ADD, SHIFT, DONE. A 3-bit iteration counter k runs 0..7.
- IDLE:
  - Run=1: A<=0, X<=0, k<=0, go to ADD. B is retained. Run has priority over ClearA_LoadB on the same edge.
  - Run=0 and ClearA_LoadB=1: A<=0, X<=0, B<=S, stay in IDLE.
  - Otherwise: hold.
- ADD:
  - B[0]=1: X<=S9[8], A<=S9[7:0].
  - B[0]=0: X, A, B unchanged.
  - Always go to SHIFT.
- SHIFT:
  - Arithmetic right shift of X:A:B. X unchanged, A<={X,A[7:1]}, B<={A[0],B[7:1]}.
  - k<7: k<=k+1, go to ADD.
  - k=7: go to DONE.
- DONE:
  - Registers hold. Done=1.
  - Stay while Run=1 (no auto-restart). Run=0 goes to IDLE.
- Latency: 17 edges from the edge sampling Run=1 in IDLE to entry into DONE (1 setup edge + 8 x (ADD + SHIFT)). Product is valid in A:B at DONE entry.
- ClearA_LoadB and S changes outside IDLE are ignored. S must be stable while Busy=1 (bench requirement, not checked in RTL).
- Overflow is impossible: the full 16-bit signed product fits in A:B. X equals A[7] at DONE.
- Consecutive multiplies without reloading B reuse the previous B (the low product byte) as the new multiplier. This is intended.

Decomposition:
- Package mult_pkg:
  - state_t enum {IDLE, ADD, SHIFT, DONE}, 2-bit encoding.
  - Constants MULT_WIDTH=8 and MULT_ITERS=8.
- Sub-module: nine_bit_adder, instantiated once. The subtract select (~S, cin) is generated in this block.
- Registers and FSM stay in one module. No separate register-unit module.

Test Plan:
- Load B=0x03 via ClearA_LoadB, S=0x07, pulse Run -> after 17 edges Done=1, A=0x00, B=0x15, X=0.
- B=0xFF, S=0xFF (-1 x -1) -> A=0x00, B=0x01, X=0.
- B=0x80, S=0x7F (-128 x 127) -> A=0xC0, B=0x80, X=1.
- B=0x80, S=0x80 (-128 x -128) -> A=0x40, B=0x00, X=0.
- Run held high through DONE -> stays in DONE, registers stable; Run=0 -> IDLE next edge. ClearA_LoadB=1 and Run=1 same edge in IDLE -> B unchanged, computation starts.
- Reset_n asserted at iteration 4 (Busy=1) -> A=B=0, X=0, Busy=Done=0 immediately without a clock edge. After release, a new Run computes correctly (re-run the 7x3 case).
